pipe_issue_scheduler: RTL and testbench
=======================================

# pipe_issue_scheduler

Round-robin issue scheduler for the fixed-latency arithmetic pipelines built from delay-register chains. It arbitrates NUM_REQ requesters onto one datapath issue slot, enforces credit-based flow control toward the downstream result buffer, and tracks every in-flight operation in a resettable shadow pipeline. It emits the retire strobe and source ID exactly LATENCY cycles after issue, and supports a flush/drain sequence. It sits between the operand front-ends and the shared pipeline in each processing element.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- LATENCY, 8: datapath latency in cycles, ≥1; equals the CYCLE_COUNT of the governed delay chain.
- OUT_DEPTH, 8: downstream result buffer slots, which is the initial credit count, ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- issue_valid  out  1  a handshake occurs this cycle (OR of req_valid & req_ready).
- issue_id  out  $clog2(NUM_REQ)  index of the granted requester; 0 when idle.
- retire_valid  out  1  the issued operation leaves the datapath.
- retire_id  out  $clog2(NUM_REQ)  ID of the retiring operation.
- credit_return  in  1  the downstream buffer freed one slot.
- credits  out  $clog2(OUT_DEPTH+1)  current credit count.
- flush_req  in  1  stop granting and drain; level or pulse.
- flush_done  out  1  one-cycle pulse when the drain completes.
- busy  out  1  in_flight ≠ 0 or state ≠ IDLE.
- credit_err  out  1  sticky; set when credit_return arrives while credits == OUT_DEPTH.

## Operation
- Reset values: req_ready 0, issue_valid 0, issue_id 0, retire_valid 0, retire_id 0, credits OUT_DEPTH, flush_done 0, busy 0, credit_err 0, rr pointer 0, in_flight 0, state IDLE.
- Eligibility: state is IDLE or RUN, the registered credits > 0, and flush_req is low.
- Arbitration: search starts at the rr pointer and wraps. The first requester with req_valid set gets req_ready. After a grant to i, the pointer becomes (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Credits:
  - Issue without return: −1.
  - Return without issue: +1.
  - Issue and return in the same cycle: unchanged.
  - A return at credits == OUT_DEPTH is dropped and sets credit_err.
  - A return does not make issue possible in the same cycle when credits == 0.
- in_flight counter (0..LATENCY): +1 on issue, −1 on retire, unchanged when both happen.
- FSM:
  - IDLE → RUN on the first issue.
  - RUN → IDLE when in_flight reaches 0 with no issue.
  - IDLE/RUN → DRAIN on flush_req.
  - DRAIN → DONE when in_flight == 0.
  - DONE → IDLE after one cycle; flush_done is high only in DONE.
  - In DRAIN and DONE no grants are made. Retire and credit updates continue.
  - flush_req held high in IDLE with nothing in flight: DRAIN → DONE within 2 cycles.
- Reset mid-operation: all in-flight shadow entries are discarded. No retire_valid is produced for them, and credits return to OUT_DEPTH.

## Timing
- The grant is combinational from req_valid and registered state. Issue happens in cycle t.
- retire_valid/retire_id assert in cycle t+LATENCY for exactly one cycle, in issue order.
- Back-to-back issue sustains 1 operation per cycle while credits last.
- credits, in_flight and FSM state update on the edge ending cycle t.

## Configuration
- PIPE_SCHED_STATS_EN defined:
  - Adds outputs stat_issue_cnt[31:0] and stat_stall_cnt[31:0], both saturating and reset to 0.
  - A stall is a cycle with any req_valid high but no grant.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package sched_pkg: the state enum (IDLE, RUN, DRAIN, DONE) and width helper functions/localparams for ID, credit and in-flight widths.
- Sub-module sched_shadow_pipe: a LATENCY-stage valid+ID shift chain, with valid bits cleared asynchronously by rst. It mirrors the timing of the governed delay chain.
- The arbiter, credit counter and FSM live in the top module.

## Test plan
- Single request: req_valid=4'b0100 at t=10 → req_ready=4'b0100, issue_id=2; retire_valid with retire_id=2 at t=18; credits 8→7.
- Fairness: all four requesters held high for 8 cycles → grants 0,1,2,3,0,1,2,3; credits reach 0; the 9th cycle gets no grant.
- Credit edge: credits=0 with credit_return at t → no grant at t, grant at t+1. Simultaneous issue and return → credits unchanged.
- Flush: 3 ops issued, then flush_req → no grants; flush_done pulses exactly one cycle after the last retire; FSM returns to IDLE.
- Reset mid-flight: rst with 5 in flight → no retire_valid afterwards, credits=8, busy=0.
- Error: credit_return at credits=8 → credit_err=1 and stays set until rst; credits stay 8.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and width helpers for the pipeline issue scheduler.
package sched_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} sched_state_e;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipe_issue_scheduler_if.sv
// Request/issue/retire bundle between the operand front-ends and the issue scheduler.
interface pipe_issue_scheduler_if
    import sched_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned OUT_DEPTH = 8
);
    localparam int unsigned IdW = id_width(NUM_REQ);
    localparam int unsigned CrW = cnt_width(OUT_DEPTH);

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic               issue_valid;
    logic [IdW-1:0]     issue_id;
    logic               retire_valid;
    logic [IdW-1:0]     retire_id;
    logic               credit_return;
    logic [CrW-1:0]     credits;
    logic               flush_req;
    logic               flush_done;
    logic               busy;
    logic               credit_err;

    modport master (
        input  req_valid, credit_return, flush_req,
        output req_ready, issue_valid, issue_id, retire_valid, retire_id,
               credits, flush_done, busy, credit_err
    );

    modport slave (
        output req_valid, credit_return, flush_req,
        input  req_ready, issue_valid, issue_id, retire_valid, retire_id,
               credits, flush_done, busy, credit_err
    );

endinterface

// File: rtl/sched_shadow_pipe.sv
// LATENCY-stage valid+ID shift chain that tracks operations through the governed delay chain.
module sched_shadow_pipe #(
    parameter int unsigned LATENCY = 8,
    parameter int unsigned IdW     = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid_i,
    input  logic [IdW-1:0] in_id_i,
    output logic           out_valid_o,
    output logic [IdW-1:0] out_id_o
);
    logic [LATENCY-1:0] valid_q;
    logic [IdW-1:0]     id_q [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) id_q[i] <= '0;
        end else begin
            valid_q[0] <= in_valid_i;
            id_q[0]    <= in_id_i;
            for (int i = 1; i < int'(LATENCY); i++) begin
                valid_q[i] <= valid_q[i-1];
                id_q[i]    <= id_q[i-1];
            end
        end
    end

    assign out_valid_o = valid_q[LATENCY-1];
    assign out_id_o    = valid_q[LATENCY-1] ? id_q[LATENCY-1] : '0;

endmodule

// File: rtl/pipe_issue_scheduler.sv
// Round-robin, credit-gated issue scheduler with flush/drain and shadow retire tracking.
// Optional saturating issue/stall counters are enabled by defining PIPE_SCHED_STATS_EN.
module pipe_issue_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned LATENCY   = 8,
    parameter int unsigned OUT_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    pipe_issue_scheduler_if.master sched_io
`ifdef PIPE_SCHED_STATS_EN
    ,
    output logic [31:0]            stat_issue_cnt,
    output logic [31:0]            stat_stall_cnt
`endif
);
    localparam int unsigned    IdW   = id_width(NUM_REQ);
    localparam int unsigned    CrW   = cnt_width(OUT_DEPTH);
    localparam int unsigned    IfW   = cnt_width(LATENCY);
    localparam logic [CrW-1:0] CrMax = CrW'(OUT_DEPTH);

    sched_state_e   state_q, state_d;
    logic [CrW-1:0] credits_q, credits_d;
    logic [IfW-1:0] in_flight_q, in_flight_d;
    logic [IdW-1:0] rr_q, rr_d;
    logic           credit_err_q, credit_err_d;

    logic           eligible, issue, retire, ret_ok;
    logic [IdW-1:0] grant_id, retire_id;
    int unsigned    idx;

    // First valid requester at or after the rr pointer, wrapping.
    always_comb begin
        eligible = (state_q == StIdle || state_q == StRun) && credits_q != '0 &&
                   !sched_io.flush_req;
        issue    = 1'b0;
        grant_id = '0;
        idx      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_q) + k) % NUM_REQ;
            if (eligible && !issue && sched_io.req_valid[IdW'(idx)]) begin
                issue    = 1'b1;
                grant_id = IdW'(idx);
            end
        end
        rr_d = rr_q;
        if (issue) rr_d = (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + IdW'(1);
    end

    // A return at full credit is dropped and latched as an error.
    always_comb begin
        ret_ok       = sched_io.credit_return && credits_q != CrMax;
        credit_err_d = credit_err_q | (sched_io.credit_return && credits_q == CrMax);
        credits_d    = credits_q;
        if (issue && !ret_ok)      credits_d = credits_q - CrW'(1);
        else if (!issue && ret_ok) credits_d = credits_q + CrW'(1);
        in_flight_d = in_flight_q;
        if (issue && !retire)      in_flight_d = in_flight_q + IfW'(1);
        else if (!issue && retire) in_flight_d = in_flight_q - IfW'(1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (sched_io.flush_req) state_d = StDrain;
                else if (issue)         state_d = StRun;
            end
            StRun: begin
                if (sched_io.flush_req)                   state_d = StDrain;
                else if (in_flight_d == '0 && !issue)     state_d = StIdle;
            end
            StDrain: if (in_flight_d == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            credits_q    <= CrMax;
            in_flight_q  <= '0;
            rr_q         <= '0;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            credits_q    <= credits_d;
            in_flight_q  <= in_flight_d;
            rr_q         <= rr_d;
            credit_err_q <= credit_err_d;
        end
    end

    sched_shadow_pipe #(
        .LATENCY (LATENCY),
        .IdW     (IdW)
    ) u_shadow (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (issue),
        .in_id_i     (grant_id),
        .out_valid_o (retire),
        .out_id_o    (retire_id)
    );

    assign sched_io.req_ready    = issue ? (NUM_REQ'(1) << grant_id) : '0;
    assign sched_io.issue_valid  = issue;
    assign sched_io.issue_id     = grant_id;
    assign sched_io.retire_valid = retire;
    assign sched_io.retire_id    = retire_id;
    assign sched_io.credits      = credits_q;
    assign sched_io.flush_done   = (state_q == StDone);
    assign sched_io.busy         = (in_flight_q != '0) || (state_q != StIdle);
    assign sched_io.credit_err   = credit_err_q;

`ifdef PIPE_SCHED_STATS_EN
    logic [31:0] issue_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (issue && issue_cnt_q != '1) issue_cnt_q <= issue_cnt_q + 32'd1;
            if ((|sched_io.req_valid) && !issue && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign stat_issue_cnt = issue_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_issue_scheduler.sv
// Bench for pipe_issue_scheduler: directed scenarios plus random traffic against a queue model.
module tb_pipe_issue_scheduler;
    localparam int NR = 4;
    localparam int L  = 8;
    localparam int OD = 8;
    localparam int MIdle = 0, MRun = 1, MDrain = 2, MDone = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_issue_scheduler_if #(.NUM_REQ(NR), .OUT_DEPTH(OD)) bus ();

`ifdef PIPE_SCHED_STATS_EN
    logic [31:0] stat_issue_cnt, stat_stall_cnt;
`endif

    pipe_issue_scheduler #(.NUM_REQ(NR), .LATENCY(L), .OUT_DEPTH(OD)) dut (
        .clk            (clk),
        .rst            (rst),
        .sched_io       (bus)
`ifdef PIPE_SCHED_STATS_EN
        ,
        .stat_issue_cnt (stat_issue_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: ops in flight are a queue of (issue cycle, id).
    int m_cyc, m_credits, m_rr, m_mode;
    bit m_err;
    int q_t[$];
    int q_id[$];

    logic [NR-1:0] e_ready;
    logic          e_issue, e_ret, e_done, e_busy, e_err;
    logic [1:0]    e_id, e_rid;
    logic [3:0]    e_credits;
    logic          s_cr, s_fl;

    task automatic m_reset();
        m_cyc = 0; m_credits = OD; m_rr = 0; m_mode = MIdle; m_err = 0;
        q_t.delete(); q_id.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0; bus.credit_return = 1'b0; bus.flush_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic step(input logic [NR-1:0] rv, input logic cr, input logic fl);
        int idx;
        @(negedge clk);
        bus.req_valid = rv; bus.credit_return = cr; bus.flush_req = fl;
        s_cr = cr; s_fl = fl;
        #1;
        e_credits = 4'(m_credits);
        e_err     = m_err;
        e_done    = (m_mode == MDone);
        e_busy    = (q_t.size() != 0) || (m_mode != MIdle);
        e_ret     = (q_t.size() > 0) && (q_t[0] + L == m_cyc);
        e_rid     = e_ret ? 2'(q_id[0]) : 2'd0;
        e_issue = 1'b0; e_id = '0; e_ready = '0;
        if ((m_mode == MIdle || m_mode == MRun) && m_credits > 0 && !fl) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_rr + k) % NR;
                if (!e_issue && rv[idx]) begin
                    e_issue = 1'b1;
                    e_id = 2'(idx);
                end
            end
        end
        if (e_issue) e_ready[e_id] = 1'b1;
    endtask

    task automatic advance();
        if (e_ret) begin
            void'(q_t.pop_front());
            void'(q_id.pop_front());
        end
        if (e_issue) begin
            q_t.push_back(m_cyc);
            q_id.push_back(int'(e_id));
            m_rr = (int'(e_id) + 1) % NR;
        end
        if (s_cr && m_credits == OD) m_err = 1;
        m_credits = m_credits + ((s_cr && m_credits != OD) ? 1 : 0) - (e_issue ? 1 : 0);
        case (m_mode)
            MIdle:  if (s_fl) m_mode = MDrain; else if (e_issue) m_mode = MRun;
            MRun:   if (s_fl) m_mode = MDrain;
                    else if (q_t.size() == 0 && !e_issue) m_mode = MIdle;
            MDrain: if (q_t.size() == 0) m_mode = MDone;
            default: m_mode = MIdle;
        endcase
        m_cyc++;
    endtask

    task automatic test_reset();
        step('0, 1'b0, 1'b0);
        total++;
        if (bus.req_ready !== '0 || bus.issue_valid !== 1'b0 || bus.issue_id !== '0) begin
            bad++;
            $display("FAIL reset_grant: ready=%b valid=%b id=%0d want 0 0 0",
                     bus.req_ready, bus.issue_valid, bus.issue_id);
        end
        total++;
        if (bus.credits !== 4'd8) begin
            bad++; $display("FAIL reset_credits: got %0d want 8", bus.credits);
        end
        total++;
        if (bus.retire_valid !== 1'b0 || bus.retire_id !== '0) begin
            bad++; $display("FAIL reset_retire: got %b/%0d want 0/0", bus.retire_valid, bus.retire_id);
        end
        total++;
        if (bus.busy !== 1'b0 || bus.flush_done !== 1'b0 || bus.credit_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: busy=%b done=%b err=%b want 0 0 0",
                     bus.busy, bus.flush_done, bus.credit_err);
        end
        advance();
    endtask

    task automatic test_single();
        step('0, 1'b0, 1'b0); advance();
        step(4'b0100, 1'b0, 1'b0);
        total++;
        if (bus.req_ready !== 4'b0100 || bus.issue_id !== 2'd2) begin
            bad++;
            $display("FAIL single_grant: ready=%b id=%0d want 0100 2", bus.req_ready, bus.issue_id);
        end
        advance();
        for (int k = 1; k <= L; k++) begin
            step('0, 1'b0, 1'b0);
            if (k == 1) begin
                total++;
                if (bus.credits !== 4'd7) begin
                    bad++; $display("FAIL single_credits: got %0d want 7", bus.credits);
                end
            end
            total++;
            if (bus.retire_valid !== (k == L) || (k == L && bus.retire_id !== 2'd2)) begin
                bad++;
                $display("FAIL single_retire k=%0d: got %b/%0d want %b/2",
                         k, bus.retire_valid, bus.retire_id, (k == L));
            end
            advance();
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step('1, 1'b0, 1'b0);
            total++;
            if (bus.issue_valid !== 1'b1 || bus.issue_id !== 2'(k % NR)) begin
                bad++;
                $display("FAIL fair_grant k=%0d: got %b/%0d want 1/%0d",
                         k, bus.issue_valid, bus.issue_id, k % NR);
            end
            advance();
        end
        step('1, 1'b0, 1'b0);
        total++;
        if (bus.issue_valid !== 1'b0 || bus.credits !== 4'd0) begin
            bad++;
            $display("FAIL fair_exhaust: valid=%b credits=%0d want 0 0", bus.issue_valid, bus.credits);
        end
        advance();
    endtask

    task automatic test_credit_edge();
        step('1, 1'b1, 1'b0);
        total++;
        if (bus.issue_valid !== 1'b0) begin
            bad++; $display("FAIL credit_same_cycle: got valid=%b want 0", bus.issue_valid);
        end
        advance();
        step('1, 1'b0, 1'b0);
        total++;
        if (bus.issue_valid !== 1'b1 || bus.issue_id !== 2'd0 || bus.credits !== 4'd1) begin
            bad++;
            $display("FAIL credit_next_cycle: got %b/%0d cr=%0d want 1/0 cr=1",
                     bus.issue_valid, bus.issue_id, bus.credits);
        end
        advance();
        step('1, 1'b1, 1'b0); advance();
        step('1, 1'b1, 1'b0);
        total++;
        if (bus.issue_valid !== 1'b1 || bus.issue_id !== 2'd1) begin
            bad++; $display("FAIL credit_both_grant: got %b/%0d want 1/1", bus.issue_valid, bus.issue_id);
        end
        advance();
        step('0, 1'b0, 1'b0);
        total++;
        if (bus.credits !== 4'd1) begin
            bad++; $display("FAIL credit_both_hold: got %0d want 1", bus.credits);
        end
        advance();
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 3; c++) begin step('1, 1'b0, 1'b0); advance(); end
        step('1, 1'b0, 1'b1);
        total++;
        if (bus.issue_valid !== 1'b0) begin
            bad++; $display("FAIL flush_block: got valid=%b want 0", bus.issue_valid);
        end
        advance();
        for (int c = 4; c <= 12; c++) begin
            step('1, 1'b0, 1'b0);
            total++;
            if (bus.issue_valid !== (c == 12)) begin
                bad++; $display("FAIL flush_grant c=%0d: got %b want %b", c, bus.issue_valid, (c == 12));
            end
            total++;
            if (bus.flush_done !== (c == 11)) begin
                bad++; $display("FAIL flush_done c=%0d: got %b want %b", c, bus.flush_done, (c == 11));
            end
            total++;
            if (bus.retire_valid !== (c >= 8 && c <= 10)) begin
                bad++;
                $display("FAIL flush_retire c=%0d: got %b want %b",
                         c, bus.retire_valid, (c >= 8 && c <= 10));
            end
            advance();
        end
        repeat (10) begin step('0, 1'b0, 1'b0); advance(); end
        step('0, 1'b0, 1'b0);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL flush_idle_busy: got %b want 0", bus.busy);
        end
        advance();
    endtask

    task automatic test_flush_idle();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            step('0, 1'b0, 1'b1);
            total++;
            if (bus.flush_done !== (c == 2)) begin
                bad++; $display("FAIL flush_idle c=%0d: got %b want %b", c, bus.flush_done, (c == 2));
            end
            advance();
        end
        repeat (3) begin step('0, 1'b0, 1'b0); advance(); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int c = 0; c < 5; c++) begin step('1, 1'b0, 1'b0); advance(); end
        do_reset();
        for (int k = 0; k < L + 2; k++) begin
            step('0, 1'b0, 1'b0);
            if (k == 0) begin
                total++;
                if (bus.credits !== 4'd8 || bus.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL midreset_state: credits=%0d busy=%b want 8 0", bus.credits, bus.busy);
                end
            end
            total++;
            if (bus.retire_valid !== 1'b0) begin
                bad++; $display("FAIL midreset_retire k=%0d: got %b want 0", k, bus.retire_valid);
            end
            advance();
        end
    endtask

    task automatic test_credit_error();
        step('0, 1'b1, 1'b0);
        advance();
        for (int k = 0; k < 4; k++) begin
            step('0, 1'b0, 1'b0);
            total++;
            if (bus.credit_err !== 1'b1 || bus.credits !== 4'd8) begin
                bad++;
                $display("FAIL credit_err k=%0d: err=%b credits=%0d want 1 8",
                         k, bus.credit_err, bus.credits);
            end
            advance();
        end
        do_reset();
        step('0, 1'b0, 1'b0);
        total++;
        if (bus.credit_err !== 1'b0) begin
            bad++; $display("FAIL credit_err_clear: got %b want 0", bus.credit_err);
        end
        advance();
    endtask

    task automatic test_random();
        logic [NR-1:0] rv;
        logic cr, fl;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rv = NR'($urandom & $urandom);
            cr = (m_credits < OD) && ($urandom_range(0, 1) == 0);
            fl = ($urandom_range(0, 29) == 0);
            step(rv, cr, fl);
            total++;
            if (bus.req_ready !== e_ready || bus.issue_valid !== e_issue || bus.issue_id !== e_id) begin
                bad++;
                $display("FAIL rand_grant n=%0d: got %b/%b/%0d want %b/%b/%0d", n, bus.req_ready,
                         bus.issue_valid, bus.issue_id, e_ready, e_issue, e_id);
            end
            total++;
            if (bus.retire_valid !== e_ret || bus.retire_id !== e_rid) begin
                bad++;
                $display("FAIL rand_retire n=%0d: got %b/%0d want %b/%0d",
                         n, bus.retire_valid, bus.retire_id, e_ret, e_rid);
            end
            total++;
            if (bus.credits !== e_credits || bus.flush_done !== e_done || bus.busy !== e_busy ||
                bus.credit_err !== e_err) begin
                bad++;
                $display("FAIL rand_status n=%0d: got cr=%0d done=%b busy=%b err=%b want %0d %b %b %b",
                         n, bus.credits, bus.flush_done, bus.busy, bus.credit_err,
                         e_credits, e_done, e_busy, e_err);
            end
            advance();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req_valid = '0; bus.credit_return = 1'b0; bus.flush_req = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_credit_edge();
        test_flush();
        test_flush_idle();
        test_reset_midflight();
        test_credit_error();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
